// File: rtl/analyzer_pkg.sv
// Shared definitions for the trace capture/readback path: capture state encoding and
// the trace-buffer geometry helpers.
package analyzer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPretrig,
    StPosttrig,
    StFlush
  } capture_state_e;

  function automatic int unsigned words_per_packet(input int unsigned packet_width,
                                                   input int unsigned word_bytes);
    return packet_width / 8 / word_bytes;
  endfunction

  function automatic int unsigned max_sample_number(input int unsigned capacity,
                                                    input int unsigned word_bytes,
                                                    input int unsigned packet_width);
    return capacity / word_bytes / words_per_packet(packet_width, word_bytes) - 1;
  endfunction

  localparam int unsigned WORDS_PER_PACKET = words_per_packet(32, 2);
  localparam int unsigned MAX_SAMPLE_NUMBER = max_sample_number(2 ** 27, 2, 32);

endpackage

// File: rtl/analyzer_capture_write_fsm_if.sv
// Memory-interface write port: request/allow handshake with packet index and data.
interface analyzer_capture_write_fsm_if #(
  parameter int unsigned SAMPLE_PACKET_WIDTH = 32
);
  logic                           write_req;
  logic                           write_allowed;
  logic [31:0]                    writeSampleNumber;
  logic [SAMPLE_PACKET_WIDTH-1:0] write_data;

  modport master (
    output write_req,
    output writeSampleNumber,
    output write_data,
    input  write_allowed
  );

  modport slave (
    input  write_req,
    input  writeSampleNumber,
    input  write_data,
    output write_allowed
  );
endinterface

// File: rtl/analyzer_packet_holding_reg.sv
// Single-entry valid/ready holding register; a load while full and not draining is
// reported as a drop.
module analyzer_packet_holding_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  output logic             load_o,
  output logic             accept_o,
  output logic             drop_o
);
  logic             full_q, full_d;
  logic [Width-1:0] data_q, data_d;
  logic             accept, load;

  always_comb begin
    accept = full_q & out_ready_i;
    // Reload in the same cycle as acceptance keeps the stream bubble-free.
    load   = in_valid_i & (~full_q | accept);
    full_d = full_q;
    data_d = data_q;
    if (accept) full_d = 1'b0;
    if (load) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_valid_o = full_q;
  assign out_data_o  = data_q;
  assign load_o      = load;
  assign accept_o    = accept;
  assign drop_o      = in_valid_i & ~load;

endmodule

// File: rtl/analyzer_capture_write_fsm.sv
// Capture-side FSM: packs armed samples into stamped packets, writes them into the circular
// trace buffer and reports the Begin/End/trigger packet indices for readback.
module analyzer_capture_write_fsm
  import analyzer_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH        = 16,
  parameter int unsigned SAMPLE_PACKET_WIDTH = 32,
  parameter int unsigned MEMORY_CAPACITY     = 2 ** 27,
  parameter int unsigned MEMORY_WORD_WIDTH   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    trigger,
  input  logic [31:0]             post_trig_count,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  analyzer_capture_write_fsm_if.master wr,
  output logic                    idle,
  output logic [31:0]             sampleNumber_Begin,
  output logic [31:0]             sampleNumber_End,
  output logic [31:0]             trigSampleNumber,
  output logic                    wrapped,
  output logic                    overflow
);
  localparam int unsigned StampBits = SAMPLE_PACKET_WIDTH - SAMPLE_WIDTH;
  localparam logic [31:0] MaxSample =
      32'(max_sample_number(MEMORY_CAPACITY, MEMORY_WORD_WIDTH, SAMPLE_PACKET_WIDTH));

  capture_state_e state_q, state_d;
  logic [31:0] stamp_q, stamp_d, addr_q, addr_d, remaining_q, remaining_d;
  logic [31:0] last_q, last_d, trig_q, trig_d, begin_q, begin_d, end_q, end_d;
  logic        wrapped_q, wrapped_d, overflow_q, overflow_d, written_q, written_d;

  logic                           hold_in_valid, hold_valid, hold_load, hold_accept, hold_drop;
  logic [SAMPLE_PACKET_WIDTH-1:0] packet, hold_data;
  logic [31:0]                    addr_next;

  assign hold_in_valid = sample_valid & ((state_q == StPretrig) | (state_q == StPosttrig));
  assign packet        = {stamp_q[StampBits-1:0], sample_data};
  assign addr_next     = (addr_q == MaxSample) ? 32'd0 : addr_q + 32'd1;

  analyzer_packet_holding_reg #(
    .Width(SAMPLE_PACKET_WIDTH)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (hold_in_valid),
    .in_data_i  (packet),
    .out_ready_i(wr.write_allowed),
    .out_valid_o(hold_valid),
    .out_data_o (hold_data),
    .load_o     (hold_load),
    .accept_o   (hold_accept),
    .drop_o     (hold_drop)
  );

  always_comb begin
    state_d     = state_q;
    stamp_d     = stamp_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    last_d      = last_q;
    trig_d      = trig_q;
    begin_d     = begin_q;
    end_d       = end_q;
    wrapped_d   = wrapped_q;
    overflow_d  = overflow_q;
    written_d   = written_q;

    if (state_q != StIdle) stamp_d = stamp_q + 32'd1;
    if (hold_accept) begin
      addr_d    = addr_next;
      last_d    = addr_q;
      written_d = 1'b1;
      if (addr_q == MaxSample) wrapped_d = 1'b1;
    end
    if (hold_drop) overflow_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (arm) begin
          state_d     = StPretrig;
          stamp_d     = '0;
          addr_d      = '0;
          wrapped_d   = 1'b0;
          overflow_d  = 1'b0;
          written_d   = 1'b0;
          remaining_d = post_trig_count;
        end
      end
      StPretrig: begin
        if (abort) begin
          state_d = StFlush;
        end else if (hold_load && trigger) begin
          // addr_d is the slot the freshly loaded sample will be written to.
          trig_d  = addr_d;
          state_d = (remaining_q == 32'd0) ? StFlush : StPosttrig;
        end
      end
      StPosttrig: begin
        if (hold_load) begin
          remaining_d = remaining_q - 32'd1;
          if (remaining_q == 32'd1) state_d = StFlush;
        end
        if (abort) state_d = StFlush;
      end
      StFlush: begin
        if (!hold_valid) begin
          state_d = StIdle;
          end_d   = written_q ? last_q : 32'd0;
          begin_d = (written_q && wrapped_q) ?
                    ((last_q == MaxSample) ? 32'd0 : last_q + 32'd1) : 32'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      stamp_q     <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      last_q      <= '0;
      trig_q      <= '0;
      begin_q     <= '0;
      end_q       <= '0;
      wrapped_q   <= 1'b0;
      overflow_q  <= 1'b0;
      written_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stamp_q     <= stamp_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      last_q      <= last_d;
      trig_q      <= trig_d;
      begin_q     <= begin_d;
      end_q       <= end_d;
      wrapped_q   <= wrapped_d;
      overflow_q  <= overflow_d;
      written_q   <= written_d;
    end
  end

  assign wr.write_req          = hold_valid;
  assign wr.write_data         = hold_data;
  assign wr.writeSampleNumber  = addr_q;
  assign idle                  = (state_q == StIdle);
  assign sampleNumber_Begin    = begin_q;
  assign sampleNumber_End      = end_q;
  assign trigSampleNumber      = trig_q;
  assign wrapped               = wrapped_q;
  assign overflow              = overflow_q;

endmodule

// File: tb/tb_analyzer_capture_write_fsm.sv
// Bench: two instances (default buffer and an 8-packet buffer) driven by the same stimulus and
// checked each cycle against a transaction-level model of the capture rules.
module tb_analyzer_capture_write_fsm;
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_POST = 2, PH_DRAIN = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1, arm = 1'b0, abort = 1'b0, trigger = 1'b0;
  logic        sample_valid = 1'b0, write_allowed = 1'b0;
  logic [31:0] post_trig_count = '0;
  logic [15:0] sample_data = '0;

  always #5 clk = ~clk;

  analyzer_capture_write_fsm_if #(.SAMPLE_PACKET_WIDTH(32)) wr0 ();
  analyzer_capture_write_fsm_if #(.SAMPLE_PACKET_WIDTH(32)) wr1 ();
  assign wr0.write_allowed = write_allowed;
  assign wr1.write_allowed = write_allowed;

  logic        o_req[2], o_idle[2], o_wrapped[2], o_ovf[2];
  logic [31:0] o_addr[2], o_data[2], o_begin[2], o_end[2], o_trig[2];
  assign o_req[0]  = wr0.write_req;
  assign o_req[1]  = wr1.write_req;
  assign o_addr[0] = wr0.writeSampleNumber;
  assign o_addr[1] = wr1.writeSampleNumber;
  assign o_data[0] = wr0.write_data;
  assign o_data[1] = wr1.write_data;

  analyzer_capture_write_fsm dut0 (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trigger(trigger),
    .post_trig_count(post_trig_count), .sample_valid(sample_valid), .sample_data(sample_data),
    .wr(wr0), .idle(o_idle[0]), .sampleNumber_Begin(o_begin[0]), .sampleNumber_End(o_end[0]),
    .trigSampleNumber(o_trig[0]), .wrapped(o_wrapped[0]), .overflow(o_ovf[0])
  );

  analyzer_capture_write_fsm #(.MEMORY_CAPACITY(32)) dut1 (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trigger(trigger),
    .post_trig_count(post_trig_count), .sample_valid(sample_valid), .sample_data(sample_data),
    .wr(wr1), .idle(o_idle[1]), .sampleNumber_Begin(o_begin[1]), .sampleNumber_End(o_end[1]),
    .trigSampleNumber(o_trig[1]), .wrapped(o_wrapped[1]), .overflow(o_ovf[1])
  );

  // Reference model: number of packet slots = capacity / bytes-per-word / words-per-packet.
  longint unsigned m_size[2] = '{(64'd1 << 27) / 2 / (32 / 8 / 2), 64'd32 / 2 / (32 / 8 / 2)};
  int          m_ph[2];
  logic        m_pend[2], m_wrapped[2], m_ovf[2], m_written[2];
  logic [31:0] m_addr[2], m_data[2], m_stamp[2], m_rem[2], m_last[2];
  logic [31:0] m_trig[2], m_begin[2], m_end[2];

  int total = 0;
  int bad = 0;

  function automatic logic [163:0] dut_vec(input int k);
    return {o_req[k], o_addr[k], o_data[k], o_idle[k], o_begin[k], o_end[k], o_trig[k],
            o_wrapped[k], o_ovf[k]};
  endfunction

  function automatic logic [163:0] model_vec(input int k);
    return {m_pend[k], m_addr[k], m_data[k], 1'(m_ph[k] == PH_IDLE), m_begin[k], m_end[k],
            m_trig[k], m_wrapped[k], m_ovf[k]};
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_tick();
    for (int k = 0; k < 2; k++) begin
      logic acc, busy, cap, drop, old_pend;
      logic [31:0] slot;
      int old_ph;
      if (reset) begin
        m_ph[k] = PH_IDLE; m_pend[k] = 0; m_data[k] = 0; m_addr[k] = 0; m_stamp[k] = 0;
        m_rem[k] = 0; m_wrapped[k] = 0; m_ovf[k] = 0; m_written[k] = 0; m_last[k] = 0;
        m_trig[k] = 0; m_begin[k] = 0; m_end[k] = 0;
      end else begin
        old_ph   = m_ph[k];
        old_pend = m_pend[k];
        acc  = old_pend && write_allowed;
        busy = (old_ph == PH_WAIT) || (old_ph == PH_POST);
        cap  = busy && sample_valid && (!old_pend || acc);
        drop = busy && sample_valid && !cap;
        slot = acc ? 32'((64'(m_addr[k]) + 64'd1) % m_size[k]) : m_addr[k];
        if (acc) begin
          m_written[k] = 1;
          m_last[k]    = m_addr[k];
          if (slot == 0) m_wrapped[k] = 1;
          m_addr[k] = slot;
        end
        if (cap) begin
          m_pend[k] = 1;
          m_data[k] = {m_stamp[k][15:0], sample_data};
        end else if (acc) begin
          m_pend[k] = 0;
        end
        if (drop) m_ovf[k] = 1;
        case (old_ph)
          PH_IDLE: if (arm) begin
            m_ph[k] = PH_WAIT; m_addr[k] = 0; m_wrapped[k] = 0; m_ovf[k] = 0;
            m_written[k] = 0; m_rem[k] = post_trig_count;
          end
          PH_WAIT: begin
            if (abort) m_ph[k] = PH_DRAIN;
            else if (cap && trigger) begin
              m_trig[k] = slot;
              m_ph[k]   = (m_rem[k] == 0) ? PH_DRAIN : PH_POST;
            end
          end
          PH_POST: begin
            if (cap) begin
              m_rem[k] = m_rem[k] - 1;
              if (m_rem[k] == 0) m_ph[k] = PH_DRAIN;
            end
            if (abort) m_ph[k] = PH_DRAIN;
          end
          default: if (!old_pend) begin
            m_ph[k]    = PH_IDLE;
            m_end[k]   = m_written[k] ? m_last[k] : 32'd0;
            m_begin[k] = (m_written[k] && m_wrapped[k]) ?
                         32'((64'(m_last[k]) + 64'd1) % m_size[k]) : 32'd0;
          end
        endcase
        if (old_ph != PH_IDLE) m_stamp[k] = m_stamp[k] + 1;
        else if (arm) m_stamp[k] = 0;
      end
    end
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic a, input logic ab, input logic tr, input logic sv,
                        input logic wa);
    arm = a; abort = ab; trigger = tr; sample_valid = sv; write_allowed = wa;
    sample_data = 16'($urandom);
  endtask

  task automatic test_reset();
    reset = 1; set_in(0, 0, 0, 0, 0);
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (dut_vec(k) !== model_vec(k)) begin
        bad++; $display("FAIL reset_vec dut%0d: got %h want %h", k, dut_vec(k), model_vec(k));
      end
      total++;
      if ({o_req[k], o_idle[k], o_addr[k], o_data[k], o_ovf[k], o_end[k]} !== {2'b01, 97'd0})
      begin
        bad++; $display("FAIL reset_const dut%0d: req=%b idle=%b addr=%0d ovf=%b want 0 1 0 0",
                        k, o_req[k], o_idle[k], o_addr[k], o_ovf[k]);
      end
    end
    reset = 0; tick();
  endtask

  task automatic test_basic();
    post_trig_count = 2; set_in(1, 0, 0, 0, 1); tick();
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, c == 0, 1, 1); tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dut_vec(k) !== model_vec(k)) begin
          bad++; $display("FAIL basic_vec dut%0d c%0d: got %h want %h", k, c, dut_vec(k),
                          model_vec(k));
        end
      end
      total++;
      if (o_req[0] !== 1'b1 || o_addr[0] !== 32'(c)) begin
        bad++; $display("FAIL basic_addr c%0d: req=%b addr=%0d want 1 %0d", c, o_req[0],
                        o_addr[0], c);
      end
    end
    for (int c = 0; c < 20 && !(o_idle[0] && o_idle[1]); c++) begin
      set_in(0, 0, 0, 0, 1); tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dut_vec(k) !== model_vec(k)) begin
          bad++; $display("FAIL basic_drain dut%0d: got %h want %h", k, dut_vec(k), model_vec(k));
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({o_idle[k], o_trig[k], o_end[k], o_begin[k]} !== {1'b1, 32'd0, 32'd2, 32'd0}) begin
        bad++; $display("FAIL basic_result dut%0d: idle=%b trig=%0d end=%0d begin=%0d want 1 0 2 0",
                        k, o_idle[k], o_trig[k], o_end[k], o_begin[k]);
      end
    end
  endtask

  task automatic test_wrap();
    post_trig_count = 0; set_in(1, 0, 0, 0, 1); tick();
    for (int c = 0; c < 13 + 20 && !(c > 13 && o_idle[0] && o_idle[1]); c++) begin
      if (c < 13) set_in(0, 0, c == 12, 1, 1);
      else set_in(0, 0, 0, 0, 1);
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dut_vec(k) !== model_vec(k)) begin
          bad++; $display("FAIL wrap_vec dut%0d c%0d: got %h want %h", k, c, dut_vec(k),
                          model_vec(k));
        end
      end
    end
    total++;
    if ({o_idle[1], o_wrapped[1], o_end[1], o_begin[1], o_trig[1]} !==
        {2'b11, 32'd4, 32'd5, 32'd4}) begin
      bad++; $display("FAIL wrap_small: idle=%b wrapped=%b end=%0d begin=%0d trig=%0d want 1 1 4 5 4",
                      o_idle[1], o_wrapped[1], o_end[1], o_begin[1], o_trig[1]);
    end
    total++;
    if ({o_idle[0], o_wrapped[0], o_end[0], o_begin[0], o_trig[0]} !==
        {2'b10, 32'd12, 32'd0, 32'd12}) begin
      bad++; $display("FAIL wrap_big: idle=%b wrapped=%b end=%0d begin=%0d trig=%0d want 1 0 12 0 12",
                      o_idle[0], o_wrapped[0], o_end[0], o_begin[0], o_trig[0]);
    end
  endtask

  task automatic test_stall();
    logic [15:0] s0;
    post_trig_count = 3; set_in(1, 0, 0, 0, 1); tick();
    s0 = '0;
    for (int c = 0; c < 6 + 20 && !(c > 6 && o_idle[0] && o_idle[1]); c++) begin
      if (c < 6) set_in(0, 0, c == 0, 1, c >= 3);
      else set_in(0, 0, 0, 0, 1);
      if (c == 0) s0 = sample_data;
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dut_vec(k) !== model_vec(k)) begin
          bad++; $display("FAIL stall_vec dut%0d c%0d: got %h want %h", k, c, dut_vec(k),
                          model_vec(k));
        end
      end
      if (c < 3) begin
        total++;
        if (o_req[0] !== 1'b1 || o_addr[0] !== 32'd0 || o_data[0][15:0] !== s0) begin
          bad++; $display("FAIL stall_hold c%0d: req=%b addr=%0d data=%h want 1 0 %h", c,
                          o_req[0], o_addr[0], o_data[0][15:0], s0);
        end
      end
    end
    total++;
    if ({o_idle[0], o_ovf[0], o_end[0], o_begin[0]} !== {2'b11, 32'd3, 32'd0}) begin
      bad++; $display("FAIL stall_result: idle=%b ovf=%b end=%0d begin=%0d want 1 1 3 0",
                      o_idle[0], o_ovf[0], o_end[0], o_begin[0]);
    end
  endtask

  task automatic test_post_zero();
    int acc_cnt;
    acc_cnt = 0;
    post_trig_count = 0; set_in(1, 0, 0, 0, 1); tick();
    for (int c = 0; c < 20 && !(c > 0 && o_idle[0]); c++) begin
      set_in(0, 0, c == 0, c == 0, 1);
      if (o_req[0] && write_allowed) acc_cnt++;
      tick();
      total++;
      if (dut_vec(0) !== model_vec(0)) begin
        bad++; $display("FAIL pz_vec c%0d: got %h want %h", c, dut_vec(0), model_vec(0));
      end
    end
    total++;
    if (acc_cnt !== 1 || {o_idle[0], o_end[0], o_begin[0], o_trig[0]} !== {1'b1, 96'd0}) begin
      bad++; $display("FAIL pz_result: writes=%0d idle=%b end=%0d begin=%0d trig=%0d want 1 1 0 0 0",
                      acc_cnt, o_idle[0], o_end[0], o_begin[0], o_trig[0]);
    end
  endtask

  task automatic test_abort();
    post_trig_count = 5; set_in(1, 0, 0, 0, 1); tick();
    for (int c = 0; c < 7; c++) begin
      if (c < 4) set_in(0, 0, 0, 1, 1);
      else if (c == 4) set_in(0, 1, 0, 0, 1);
      else if (c == 5) set_in(1, 0, 0, 0, 1);
      else set_in(0, 0, 0, 0, 1);
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dut_vec(k) !== model_vec(k)) begin
          bad++; $display("FAIL abort_vec dut%0d c%0d: got %h want %h", k, c, dut_vec(k),
                          model_vec(k));
        end
      end
    end
    total++;
    if ({o_idle[0], o_end[0], o_begin[0], o_trig[0]} !== {1'b1, 32'd3, 64'd0}) begin
      bad++; $display("FAIL abort_result: idle=%b end=%0d begin=%0d trig=%0d want 1 3 0 0",
                      o_idle[0], o_end[0], o_begin[0], o_trig[0]);
    end
  endtask

  task automatic test_reset_mid();
    post_trig_count = 10; set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 0, 1, 1, 0); tick();
    set_in(0, 0, 0, 1, 0); tick();
    total++;
    if (o_req[0] !== 1'b1 || o_idle[0] !== 1'b0) begin
      bad++; $display("FAIL rmid_pre: req=%b idle=%b want 1 0", o_req[0], o_idle[0]);
    end
    reset = 1; set_in(0, 0, 0, 1, 0); tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({o_req[k], o_idle[k], o_addr[k], o_data[k], o_begin[k], o_end[k], o_trig[k],
           o_wrapped[k], o_ovf[k]} !== {2'b01, 162'd0}) begin
        bad++; $display("FAIL rmid_reset dut%0d: got %h want reset values", k, dut_vec(k));
      end
    end
    reset = 0;
    post_trig_count = 0; set_in(1, 0, 0, 0, 1); tick();
    set_in(0, 0, 1, 1, 1); tick();
    total++;
    if (o_req[0] !== 1'b1 || o_addr[0] !== 32'd0) begin
      bad++; $display("FAIL rmid_rearm: req=%b addr=%0d want 1 0", o_req[0], o_addr[0]);
    end
    for (int c = 0; c < 20 && !(o_idle[0] && o_idle[1]); c++) begin
      set_in(0, 0, 0, 0, 1); tick();
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (dut_vec(k) !== model_vec(k)) begin
        bad++; $display("FAIL rmid_done dut%0d: got %h want %h", k, dut_vec(k), model_vec(k));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      set_in($urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 5) == 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      post_trig_count = $urandom_range(0, 4);
      reset = ($urandom_range(0, 499) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dut_vec(k) !== model_vec(k)) begin
          bad++; $display("FAIL random_vec dut%0d c%0d: got %h want %h", k, c, dut_vec(k),
                          model_vec(k));
        end
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_post_zero();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/analyzer_capture_write_fsm.md
Name: analyzer_capture_write_fsm

Overview:
Write-side counterpart of the trace readback path. Once armed, it packs incoming samples into packets and writes them into the circular DRAM trace buffer through the memory interface's write request/allow handshake. It waits for a trigger, captures a programmed number of post-trigger samples, and then reports the Begin/End sample numbers that the readback FSM later uses. Sits between the sampler front-end and the memory interface write port.

Parameters:
SAMPLE_WIDTH, 16, width of one raw sample.
SAMPLE_PACKET_WIDTH, 32, width of one stored packet; must exceed SAMPLE_WIDTH.
MEMORY_CAPACITY, 2**27, trace memory size in bytes.
MEMORY_WORD_WIDTH, 2, bytes per memory word.
Derived: WORDS_PER_PACKET = SAMPLE_PACKET_WIDTH/8/MEMORY_WORD_WIDTH; MAX_SAMPLE_NUMBER = MEMORY_CAPACITY/MEMORY_WORD_WIDTH/WORDS_PER_PACKET - 1 (default 2**25-1).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
arm  in  1  start-capture pulse; honoured only in IDLE
abort  in  1  end capture early; honoured in PRETRIG/POSTTRIG
trigger  in  1  trigger qualifier for the sample presented in the same cycle
post_trig_count  in  32  samples to capture after the trigger sample; latched at arm
sample_valid  in  1  sample_data is valid this cycle
sample_data  in  SAMPLE_WIDTH  raw sample
write_req  out  1  write request to the memory interface
write_allowed  in  1  memory interface accepts the write this cycle
writeSampleNumber  out  32  packet index of the pending write
write_data  out  SAMPLE_PACKET_WIDTH  {stamp[PW-SW-1:0], sample}
idle  out  1  high in IDLE; feeds the readback FSM's idle input
sampleNumber_Begin  out  32  oldest valid packet index
sampleNumber_End  out  32  newest valid packet index
trigSampleNumber  out  32  packet index of the trigger sample
wrapped  out  1  buffer wrapped at least once during this capture
overflow  out  1  sticky; a sample was dropped

Behaviour:
- Reset values: write_req=0, writeSampleNumber=0, write_data=0, idle=1, Begin=End=trigSampleNumber=0, wrapped=0, overflow=0, state=IDLE. Any pending packet is discarded.
- Reset mid-operation: returns to IDLE in the next cycle. write_req drops in that cycle; no further writes.
- States:
  - IDLE: arm -> PRETRIG. On arm: clear writeSampleNumber, stamp, wrapped and overflow; latch post_trig_count; idle goes low next cycle.
  - PRETRIG: sample_valid & trigger -> capture that sample as the trigger sample and latch its index into trigSampleNumber. If the latched count is 0, go to FLUSH; otherwise go to POSTTRIG with remaining = count.
  - POSTTRIG: each captured sample decrements remaining. When the sample that brings remaining to 0 is captured, go to FLUSH.
  - FLUSH: wait until the holding register is empty, then compute Begin/End, go to IDLE, and drive idle=1.
  - abort in PRETRIG/POSTTRIG -> FLUSH. A sample valid in the same cycle is still captured, but its trigger is ignored.
- Stamp: 32-bit free-running cycle counter, cleared at arm and incremented every non-IDLE cycle. Its low PW-SW bits are packed into write_data.
- Holding register (one entry):
  - A sample_valid with the register empty, or emptying this cycle, loads it. write_req/data/address appear the next cycle.
  - write_req, write_data and writeSampleNumber stay stable until write_req & write_allowed.
  - Back-to-back: acceptance and reload in the same cycle give one packet per cycle with no bubble.
  - sample_valid with the register full and not accepted: sample dropped, overflow set. A dropped sample is not counted against remaining.
- Address: writeSampleNumber advances on each acceptance. MAX_SAMPLE_NUMBER -> 0 sets wrapped.
- Completion:
  - End = index of the last accepted packet.
  - Begin = wrapped ? (End==MAX ? 0 : End+1) : 0.
  - If no packet was written, Begin=End=0.
- Ignored inputs: arm outside IDLE; trigger outside PRETRIG; sample_valid in IDLE and FLUSH.

Decomposition:
- Shared package analyzer_pkg: derived localparams (WORDS_PER_PACKET, MAX_SAMPLE_NUMBER) and the capture state encoding (IDLE, PRETRIG, POSTTRIG, FLUSH). The readback FSM reuses MAX_SAMPLE_NUMBER from the same package.
- One sub-module: analyzer_packet_holding_reg, the single-entry valid/ready holding register with a drop/overflow indication.

Test Plan:
- Arm; 3 valid samples, trigger on sample 0, post_trig_count=2, write_allowed=1 -> packets at indices 0,1,2 with write_req one cycle after each sample; trigSampleNumber=0, End=2, Begin=0, idle=1 after FLUSH.
- MEMORY_CAPACITY=32 (MAX=7); 12 pre-trigger samples, trigger on the 13th, post=0 -> indices wrap 7->0, wrapped=1, End=4, Begin=5.
- write_allowed low for 3 cycles with a continuous sample_valid stream -> write_req/data/address held stable; 2 samples dropped; overflow=1; address sequence still contiguous.
- post_trig_count=0 with trigger on the first sample -> exactly one packet written; End=0, Begin=0, trigSampleNumber=0.
- abort in PRETRIG after 4 samples -> FLUSH; End=3, trigSampleNumber unchanged (0); arm issued during FLUSH is ignored.
- reset asserted while write_req=1 in POSTTRIG -> write_req=0 and idle=1 next cycle, all outputs at reset values; re-arm starts again at index 0.
